// File: rtl/rpn_pkg.sv
// Shared definitions for the rpn_eval postfix evaluator: operator ASCII codes,
// error-cause codes and FSM states.
package rpn_pkg;

  localparam logic [7:0] OP_ADD = 8'h2B;  // '+'
  localparam logic [7:0] OP_SUB = 8'h2D;  // '-'
  localparam logic [7:0] OP_MUL = 8'h2A;  // '*'
  localparam logic [7:0] OP_AND = 8'h26;  // '&'
  localparam logic [7:0] OP_OR  = 8'h7C;  // '|'
  localparam logic [7:0] OP_XOR = 8'h5E;  // '^'
  localparam logic [7:0] OP_DIV = 8'h2F;  // '/'
  localparam logic [7:0] OP_MOD = 8'h25;  // '%'

  localparam logic [2:0] ERR_NONE       = 3'd0;
  localparam logic [2:0] ERR_UNDERFLOW  = 3'd1;
  localparam logic [2:0] ERR_OVERFLOW   = 3'd2;
  localparam logic [2:0] ERR_DIV_ZERO   = 3'd3;
  localparam logic [2:0] ERR_BAD_OP     = 3'd4;
  localparam logic [2:0] ERR_PROTOCOL   = 3'd5;
  localparam logic [2:0] ERR_NOT_SINGLE = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXEC  = 2'd1,
    ST_DIV   = 2'd2,
    ST_ERROR = 2'd3
  } rpn_state_e;

  function automatic logic is_alu_op(input logic [7:0] code);
    return (code == OP_ADD) || (code == OP_SUB) || (code == OP_MUL) ||
           (code == OP_AND) || (code == OP_OR)  || (code == OP_XOR);
  endfunction

  function automatic logic is_div_op(input logic [7:0] code);
    return (code == OP_DIV) || (code == OP_MOD);
  endfunction

endpackage

// File: rtl/rpn_div.sv
// Iterative restoring divider for rpn_eval: START loads operands, DONE flags the
// cycle whose step produces the final quotient/remainder on QUOT/REM.
module rpn_div
  import rpn_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              ABORT,
  input  logic              START,
  input  logic [DATA_W-1:0] DIVIDEND,
  input  logic [DATA_W-1:0] DIVISOR,
  output logic              DONE,
  output logic [DATA_W-1:0] QUOT,
  output logic [DATA_W-1:0] REM
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  logic [DATA_W-1:0] quo_r, rem_r, dsr_r;
  logic [CNT_W-1:0]  cnt_r;
  logic              run_r;
  logic [DATA_W:0]   shifted_s, diff_s;
  logic [DATA_W-1:0] quo_nx_s, rem_nx_s;

  // One restoring step; a set borrow bit means the trial subtraction is undone.
  always_comb begin
    shifted_s = {rem_r, quo_r[DATA_W-1]};
    diff_s    = shifted_s - {1'b0, dsr_r};
    if (diff_s[DATA_W]) begin
      rem_nx_s = shifted_s[DATA_W-1:0];
      quo_nx_s = {quo_r[DATA_W-2:0], 1'b0};
    end else begin
      rem_nx_s = diff_s[DATA_W-1:0];
      quo_nx_s = {quo_r[DATA_W-2:0], 1'b1};
    end
  end

  assign DONE = run_r && (cnt_r == CNT_W'(1));
  assign QUOT = quo_nx_s;
  assign REM  = rem_nx_s;

  // Iteration register: load on START, step DATA_W times, ABORT drops the job.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      quo_r <= '0;
      rem_r <= '0;
      dsr_r <= '0;
      cnt_r <= '0;
      run_r <= 1'b0;
    end else if (ABORT) begin
      cnt_r <= '0;
      run_r <= 1'b0;
    end else if (START) begin
      quo_r <= DIVIDEND;
      rem_r <= '0;
      dsr_r <= DIVISOR;
      cnt_r <= CNT_W'(DATA_W);
      run_r <= 1'b1;
    end else if (run_r) begin
      quo_r <= quo_nx_s;
      rem_r <= rem_nx_s;
      cnt_r <= cnt_r - CNT_W'(1);
      run_r <= (cnt_r != CNT_W'(1));
    end else begin
      run_r <= 1'b0;
    end
  end

endmodule

// File: rtl/rpn_eval.sv
// Postfix (RPN) evaluator with an operand stack and sticky error reporting.
// Define RPN_DIV_EN to add "/" and "%" through the iterative rpn_div unit.
module rpn_eval
  import rpn_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 16,
  parameter int DEPTH_W = $clog2(DEPTH + 1)
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               NUM_STB,
  input  logic [DATA_W-1:0]  NUM_DAT,
  input  logic               OP_STB,
  input  logic [7:0]         OP_CODE,
  input  logic               END_STB,
  input  logic               CLR_STB,
  output logic               BUSY,
  output logic [DATA_W-1:0]  RESULT,
  output logic               RESULT_VLD,
  output logic               ERR,
  output logic [2:0]         ERR_CODE,
  output logic [DEPTH_W-1:0] STK_CNT
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [DEPTH_W-1:0] FULL_CNT = DEPTH_W'(DEPTH);

  rpn_state_e state_r, state_nx_s;
  logic [DATA_W-1:0]  stack_r [DEPTH];
  logic [DEPTH_W-1:0] cnt_r, cnt_nx_s;
  logic [DATA_W-1:0]  opa_r, opb_r, result_r, alu_s, wr_dat_s, top_s, sec_s;
  logic [7:0]         op_r;
  logic               busy_r, err_r, err_nx_s, vld_r;
  logic [2:0]         err_code_r, err_code_nx_s, raise_code_s;
  logic [IDX_W-1:0]   push_idx_s, top_idx_s, sec_idx_s;
  logic               push_s, latch_s, emit_s, wr_s, raise_s, multi_s, op_legal_s;

  assign push_idx_s = cnt_r[IDX_W-1:0];
  assign top_idx_s  = IDX_W'(cnt_r - DEPTH_W'(1));
  assign sec_idx_s  = IDX_W'(cnt_r - DEPTH_W'(2));
  assign top_s      = stack_r[top_idx_s];
  assign sec_s      = stack_r[sec_idx_s];
  assign multi_s    = (NUM_STB & OP_STB) | (NUM_STB & END_STB) | (OP_STB & END_STB);

`ifdef RPN_DIV_EN
  logic              op_div_s, div_start_s, div_done_s;
  logic [DATA_W-1:0] div_quo_s, div_rem_s;
  assign op_div_s   = is_div_op(OP_CODE);
  assign op_legal_s = is_alu_op(OP_CODE) | op_div_s;

  rpn_div #(.DATA_W(DATA_W)) u_div (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .ABORT    (CLR_STB),
    .START    (div_start_s),
    .DIVIDEND (sec_s),
    .DIVISOR  (top_s),
    .DONE     (div_done_s),
    .QUOT     (div_quo_s),
    .REM      (div_rem_s)
  );
`else
  assign op_legal_s = is_alu_op(OP_CODE);
`endif

  // Single-cycle ALU on the latched operands (unsigned, wraps modulo 2^DATA_W).
  always_comb begin
    case (op_r)
      OP_ADD:  alu_s = opa_r + opb_r;
      OP_SUB:  alu_s = opa_r - opb_r;
      OP_MUL:  alu_s = opa_r * opb_r;
      OP_AND:  alu_s = opa_r & opb_r;
      OP_OR:   alu_s = opa_r | opb_r;
      OP_XOR:  alu_s = opa_r ^ opb_r;
      default: alu_s = '0;
    endcase
  end

  // Token decode and next-state logic; CLR_STB overrides everything else.
  always_comb begin
    state_nx_s    = state_r;
    cnt_nx_s      = cnt_r;
    err_nx_s      = err_r;
    err_code_nx_s = err_code_r;
    push_s        = 1'b0;
    latch_s       = 1'b0;
    emit_s        = 1'b0;
    wr_s          = 1'b0;
    wr_dat_s      = alu_s;
    raise_s       = 1'b0;
    raise_code_s  = ERR_NONE;
`ifdef RPN_DIV_EN
    div_start_s   = 1'b0;
`endif
    if (CLR_STB) begin
      state_nx_s    = ST_IDLE;
      cnt_nx_s      = '0;
      err_nx_s      = 1'b0;
      err_code_nx_s = ERR_NONE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (multi_s) begin
            raise_s = 1'b1; raise_code_s = ERR_PROTOCOL;
          end else if (NUM_STB) begin
            if (cnt_r == FULL_CNT) begin
              raise_s = 1'b1; raise_code_s = ERR_OVERFLOW;
            end else begin
              push_s   = 1'b1;
              cnt_nx_s = cnt_r + DEPTH_W'(1);
            end
          end else if (OP_STB) begin
            if (cnt_r < DEPTH_W'(2)) begin
              raise_s = 1'b1; raise_code_s = ERR_UNDERFLOW;
            end else if (!op_legal_s) begin
              raise_s = 1'b1; raise_code_s = ERR_BAD_OP;
            end
`ifdef RPN_DIV_EN
            else if (op_div_s && (top_s == '0)) begin
              raise_s = 1'b1; raise_code_s = ERR_DIV_ZERO;
            end else if (op_div_s) begin
              latch_s     = 1'b1;
              div_start_s = 1'b1;
              state_nx_s  = ST_DIV;
            end
`endif
            else begin
              latch_s    = 1'b1;
              state_nx_s = ST_EXEC;
            end
          end else if (END_STB) begin
            if (cnt_r == DEPTH_W'(1)) begin
              emit_s   = 1'b1;
              cnt_nx_s = '0;
            end else begin
              raise_s = 1'b1; raise_code_s = ERR_NOT_SINGLE;
            end
          end else begin
            state_nx_s = ST_IDLE;
          end
        end
        ST_EXEC: begin
          wr_s       = 1'b1;
          cnt_nx_s   = cnt_r - DEPTH_W'(1);
          state_nx_s = ST_IDLE;
        end
`ifdef RPN_DIV_EN
        ST_DIV: begin
          if (div_done_s) begin
            wr_s       = 1'b1;
            wr_dat_s   = (op_r == OP_MOD) ? div_rem_s : div_quo_s;
            cnt_nx_s   = cnt_r - DEPTH_W'(1);
            state_nx_s = ST_IDLE;
          end else begin
            state_nx_s = ST_DIV;
          end
        end
`endif
        ST_ERROR: state_nx_s = ST_ERROR;
        default:  state_nx_s = ST_IDLE;
      endcase
      if (raise_s) begin
        err_nx_s      = 1'b1;
        err_code_nx_s = raise_code_s;
        state_nx_s    = ST_ERROR;
      end else begin
        err_nx_s = err_nx_s;
      end
    end
  end

  // Control and output registers.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_r    <= ST_IDLE;
      cnt_r      <= '0;
      busy_r     <= 1'b0;
      err_r      <= 1'b0;
      err_code_r <= ERR_NONE;
      result_r   <= '0;
      vld_r      <= 1'b0;
      op_r       <= 8'h00;
      opa_r      <= '0;
      opb_r      <= '0;
    end else begin
      state_r    <= state_nx_s;
      cnt_r      <= cnt_nx_s;
      busy_r     <= (state_nx_s != ST_IDLE);
      err_r      <= err_nx_s;
      err_code_r <= err_code_nx_s;
      vld_r      <= emit_s;
      if (emit_s) result_r <= stack_r[0];
      if (latch_s) begin
        op_r  <= OP_CODE;
        opa_r <= sec_s;
        opb_r <= top_s;
      end
    end
  end

  // Operand stack storage; contents are meaningless above the count.
  always_ff @(posedge CLK) begin
    if (RST_N && push_s) begin
      stack_r[push_idx_s] <= NUM_DAT;
    end else if (RST_N && wr_s) begin
      stack_r[sec_idx_s] <= wr_dat_s;
    end
  end

  assign BUSY       = busy_r;
  assign RESULT     = result_r;
  assign RESULT_VLD = vld_r;
  assign ERR        = err_r;
  assign ERR_CODE   = err_code_r;
  assign STK_CNT    = cnt_r;

endmodule

// File: tb/tb_rpn_eval.sv
// Scoreboard bench for rpn_eval: expressions push expected results, a monitor
// pops them on RESULT_VLD; error paths are checked inline in each task.
module tb_rpn_eval;

  localparam int DATA_W  = 32;
  localparam int DEPTH   = 16;
  localparam int DEPTH_W = $clog2(DEPTH + 1);

  logic               CLK = 1'b0;
  logic               RST_N = 1'b0;
  logic               NUM_STB = 1'b0;
  logic [DATA_W-1:0]  NUM_DAT = '0;
  logic               OP_STB = 1'b0;
  logic [7:0]         OP_CODE = 8'h00;
  logic               END_STB = 1'b0;
  logic               CLR_STB = 1'b0;
  logic               BUSY;
  logic [DATA_W-1:0]  RESULT;
  logic               RESULT_VLD;
  logic               ERR;
  logic [2:0]         ERR_CODE;
  logic [DEPTH_W-1:0] STK_CNT;

  int n_cmp = 0;
  int n_fail = 0;
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] sb_exp;

  rpn_eval #(.DATA_W(DATA_W), .DEPTH(DEPTH), .DEPTH_W(DEPTH_W)) dut (
    .CLK(CLK), .RST_N(RST_N), .NUM_STB(NUM_STB), .NUM_DAT(NUM_DAT),
    .OP_STB(OP_STB), .OP_CODE(OP_CODE), .END_STB(END_STB), .CLR_STB(CLR_STB),
    .BUSY(BUSY), .RESULT(RESULT), .RESULT_VLD(RESULT_VLD), .ERR(ERR),
    .ERR_CODE(ERR_CODE), .STK_CNT(STK_CNT)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (RESULT_VLD === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: RESULT=%h arrived with no expected value", RESULT);
      end else begin
        sb_exp = exp_q.pop_front();
        if (RESULT !== sb_exp) begin
          n_fail++;
          $display("FAIL sb_result: got %h expected %h", RESULT, sb_exp);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [DATA_W-1:0] ref_op(input logic [7:0] c,
                                                input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
    logic [2*DATA_W-1:0] p;
    p = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
    case (c)
      "+":     return a + b;
      "-":     return a - b;
      "*":     return p[DATA_W-1:0];
      "&":     return a & b;
      "|":     return a | b;
      "^":     return a ^ b;
      "/":     return a / b;
      "%":     return a % b;
      default: return '0;
    endcase
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (BUSY !== 1'b0 && k < 200) begin
      tick();
      k++;
    end
    n_cmp++;
    if (BUSY !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_timeout: BUSY=%b required 0", BUSY);
    end
  endtask

  task automatic send_num(input logic [DATA_W-1:0] v);
    wait_idle();
    NUM_DAT = v; NUM_STB = 1'b1;
    tick();
    NUM_STB = 1'b0;
  endtask

  task automatic send_op(input logic [7:0] c);
    wait_idle();
    OP_CODE = c; OP_STB = 1'b1;
    tick();
    OP_STB = 1'b0;
  endtask

  task automatic send_end();
    wait_idle();
    END_STB = 1'b1;
    tick();
    END_STB = 1'b0;
  endtask

  task automatic send_clr();
    CLR_STB = 1'b1;
    tick();
    CLR_STB = 1'b0;
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    tick(); tick();
    n_cmp++;
    if ({BUSY, RESULT, RESULT_VLD, ERR, ERR_CODE, STK_CNT} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: BUSY=%b RESULT=%h VLD=%b ERR=%b CODE=%0d CNT=%0d required all 0",
               BUSY, RESULT, RESULT_VLD, ERR, ERR_CODE, STK_CNT);
    end
    RST_N = 1'b1;
    tick();
  endtask

  task automatic test_arith();
    send_num(32'd3); send_num(32'd4);
    n_cmp++;
    if (STK_CNT !== DEPTH_W'(2)) begin n_fail++; $display("FAIL push_cnt: got %0d expected 2", STK_CNT); end
    send_op("+");
    n_cmp++;
    if (BUSY !== 1'b1) begin n_fail++; $display("FAIL exec_busy: got %b expected 1", BUSY); end
    send_num(32'd5); send_op("*");
    exp_q.push_back(32'd35);
    send_end();
    n_cmp++;
    if (RESULT_VLD !== 1'b1 || STK_CNT !== '0 || ERR !== 1'b0) begin
      n_fail++;
      $display("FAIL end_outputs: VLD=%b CNT=%0d ERR=%b expected 1/0/0", RESULT_VLD, STK_CNT, ERR);
    end
    tick();
    n_cmp++;
    if (RESULT_VLD !== 1'b0 || RESULT !== 32'd35) begin
      n_fail++;
      $display("FAIL vld_pulse: VLD=%b RESULT=%0d expected 0 and held 35", RESULT_VLD, RESULT);
    end
    send_num(32'd3); send_num(32'd5); send_op("-");
    exp_q.push_back(32'hFFFF_FFFE);
    send_end();
  endtask

  task automatic test_underflow();
    send_num(32'd7); send_op("+");
    n_cmp++;
    if (ERR !== 1'b1 || ERR_CODE !== 3'd1 || STK_CNT !== DEPTH_W'(1) || BUSY !== 1'b1) begin
      n_fail++;
      $display("FAIL underflow: ERR=%b CODE=%0d CNT=%0d BUSY=%b expected 1/1/1/1", ERR, ERR_CODE, STK_CNT, BUSY);
    end
    NUM_DAT = 32'd9; NUM_STB = 1'b1;
    tick();
    NUM_STB = 1'b0;
    n_cmp++;
    if (STK_CNT !== DEPTH_W'(1) || ERR_CODE !== 3'd1) begin
      n_fail++;
      $display("FAIL error_frozen: CNT=%0d CODE=%0d expected 1/1", STK_CNT, ERR_CODE);
    end
    send_clr();
    n_cmp++;
    if (ERR !== 1'b0 || ERR_CODE !== 3'd0 || STK_CNT !== '0 || BUSY !== 1'b0) begin
      n_fail++;
      $display("FAIL clear: ERR=%b CODE=%0d CNT=%0d BUSY=%b expected all 0", ERR, ERR_CODE, STK_CNT, BUSY);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < DEPTH; i++) send_num(DATA_W'(i + 1));
    n_cmp++;
    if (STK_CNT !== DEPTH_W'(DEPTH) || ERR !== 1'b0) begin
      n_fail++;
      $display("FAIL full_stack: CNT=%0d ERR=%b expected %0d/0", STK_CNT, ERR, DEPTH);
    end
    send_num(32'd99);
    n_cmp++;
    if (ERR_CODE !== 3'd2 || STK_CNT !== DEPTH_W'(DEPTH) || ERR !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow: CODE=%0d CNT=%0d ERR=%b expected 2/%0d/1", ERR_CODE, STK_CNT, ERR, DEPTH);
    end
    send_clr();
  endtask

  task automatic test_errors();
    send_num(32'd1);
    wait_idle();
    NUM_DAT = 32'd2; NUM_STB = 1'b1; OP_CODE = "+"; OP_STB = 1'b1;
    tick();
    NUM_STB = 1'b0; OP_STB = 1'b0;
    n_cmp++;
    if (ERR_CODE !== 3'd5 || STK_CNT !== DEPTH_W'(1)) begin
      n_fail++;
      $display("FAIL protocol: CODE=%0d CNT=%0d expected 5/1", ERR_CODE, STK_CNT);
    end
    send_clr();
    send_num(32'd1); send_num(32'd2); send_end();
    n_cmp++;
    if (ERR_CODE !== 3'd6 || STK_CNT !== DEPTH_W'(2)) begin
      n_fail++;
      $display("FAIL not_single: CODE=%0d CNT=%0d expected 6/2", ERR_CODE, STK_CNT);
    end
    send_clr();
    send_end();
    n_cmp++;
    if (ERR_CODE !== 3'd6 || STK_CNT !== '0) begin
      n_fail++;
      $display("FAIL end_empty: CODE=%0d CNT=%0d expected 6/0", ERR_CODE, STK_CNT);
    end
    send_clr();
    send_num(32'd1); send_num(32'd2); send_op("?");
    n_cmp++;
    if (ERR_CODE !== 3'd4 || STK_CNT !== DEPTH_W'(2)) begin
      n_fail++;
      $display("FAIL bad_op: CODE=%0d CNT=%0d expected 4/2", ERR_CODE, STK_CNT);
    end
    send_clr();
`ifndef RPN_DIV_EN
    send_num(32'd8); send_num(32'd2); send_op("/");
    n_cmp++;
    if (ERR_CODE !== 3'd4) begin n_fail++; $display("FAIL div_disabled: CODE=%0d expected 4", ERR_CODE); end
    send_clr();
`endif
    send_num(32'd9);
    wait_idle();
    NUM_DAT = 32'd10; NUM_STB = 1'b1; CLR_STB = 1'b1;
    tick();
    NUM_STB = 1'b0; CLR_STB = 1'b0;
    n_cmp++;
    if (STK_CNT !== '0 || ERR !== 1'b0 || BUSY !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_priority: CNT=%0d ERR=%b BUSY=%b expected 0/0/0", STK_CNT, ERR, BUSY);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] ops [6];
    logic [DATA_W-1:0] a, b, c;
    ops = '{"+", "-", "*", "&", "|", "^"};
    send_num(32'h0001_0001); send_num(32'h0001_0000); send_op("*");
    exp_q.push_back(32'h0001_0000);
    send_end();
    send_num(32'hF0); send_num(32'h3C); send_op("^");
    exp_q.push_back(32'hCC);
    send_end();
    for (int i = 0; i < 12; i++) begin
      a = $urandom(); b = $urandom(); c = $urandom();
      send_num(a); send_num(b); send_num(c);
      send_op(ops[i % 6]); send_op(ops[(i + 2) % 6]);
      exp_q.push_back(ref_op(ops[(i + 2) % 6], a, ref_op(ops[i % 6], b, c)));
      send_end();
    end
  endtask

`ifdef RPN_DIV_EN
  task automatic test_div();
    int n;
    logic [DATA_W-1:0] a, b;
    send_num(32'd100); send_num(32'd7); send_op("/");
    n = 0;
    while (BUSY === 1'b1 && n < 100) begin n++; tick(); end
    n_cmp++;
    if (n !== 32 || STK_CNT !== DEPTH_W'(1)) begin
      n_fail++;
      $display("FAIL div_latency: busy %0d cycles CNT=%0d expected 32/1", n, STK_CNT);
    end
    exp_q.push_back(32'd14);
    send_end();
    send_num(32'd100); send_num(32'd7); send_op("%");
    exp_q.push_back(32'd2);
    send_end();
    send_num(32'd5); send_num(32'd0); send_op("/");
    n_cmp++;
    if (ERR_CODE !== 3'd3 || STK_CNT !== DEPTH_W'(2)) begin
      n_fail++;
      $display("FAIL div_zero: CODE=%0d CNT=%0d expected 3/2", ERR_CODE, STK_CNT);
    end
    send_clr();
    send_num(32'd100); send_num(32'd7); send_op("/");
    tick(); tick(); tick();
    send_clr();
    n_cmp++;
    if (BUSY !== 1'b0 || STK_CNT !== '0) begin
      n_fail++;
      $display("FAIL div_abort: BUSY=%b CNT=%0d expected 0/0", BUSY, STK_CNT);
    end
    for (int i = 0; i < 4; i++) begin
      a = $urandom(); b = $urandom_range(1, 5000);
      send_num(a); send_num(b); send_op("/");
      exp_q.push_back(a / b);
      send_end();
      send_num(a); send_num(b); send_op("%");
      exp_q.push_back(a % b);
      send_end();
    end
    send_num(32'd100); send_num(32'd7); send_op("/");
    repeat (5) tick();
    RST_N = 1'b0;
    tick();
    n_cmp++;
    if ({BUSY, RESULT, RESULT_VLD, ERR, ERR_CODE, STK_CNT} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_div: BUSY=%b RESULT=%h VLD=%b ERR=%b CODE=%0d CNT=%0d required all 0",
               BUSY, RESULT, RESULT_VLD, ERR, ERR_CODE, STK_CNT);
    end
    RST_N = 1'b1;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_arith();
    test_underflow();
    test_overflow();
    test_errors();
    test_back_to_back();
`ifdef RPN_DIV_EN
    test_div();
`endif
    repeat (4) tick();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d results outstanding, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/rpn_eval.md
Name: rpn_eval

Overview:
- Parametrised postfix (RPN) expression evaluator with an internal operand stack, a wider operator set and error reporting.
- Accepts a stream of number and operator tokens and performs stack-based arithmetic.
- Emits one result per expression, terminated by END_STB.
- Sits between the token front-end and the result consumer.

Parameters:
- DATA_W, 32: operand, stack entry and result width.
- DEPTH, 16: operand stack entries (power of two, >= 2).
- DEPTH_W, $clog2(DEPTH+1): width of the stack-count output.

Ports:
- CLK  in  1  clock; all logic on rising edge.
- RST_N  in  1  reset, synchronous, active-low.
- NUM_STB  in  1  number token strobe.
- NUM_DAT  in  DATA_W  number token value.
- OP_STB  in  1  operator token strobe.
- OP_CODE  in  8  ASCII operator: "+", "-", "*", "&", "|", "^"; "/" and "%" only with RPN_DIV_EN.
- END_STB  in  1  end-of-expression strobe.
- CLR_STB  in  1  clear stack and error.
- BUSY  out  1  high when no token can be accepted.
- RESULT  out  DATA_W  final value; held until next result.
- RESULT_VLD  out  1  one-cycle pulse with a new RESULT.
- ERR  out  1  sticky error flag.
- ERR_CODE  out  3  error cause; valid while ERR = 1.
- STK_CNT  out  DEPTH_W  current stack occupancy.

Behaviour:
- Reset: all outputs 0, stack count 0, state IDLE.
- Reset has priority over every strobe, including mid-operation (e.g. during DIV).
- Token acceptance:
  - A token is accepted only in IDLE (BUSY = 0).
  - Strobes while BUSY = 1 are ignored, except CLR_STB.
  - More than one of NUM_STB/OP_STB/END_STB in one cycle: no stack change; ERR_CODE = 5 (PROTOCOL).
- States: IDLE, EXEC, DIV, ERROR.
- Number token:
  - Count < DEPTH: write at index count; count+1 on the same edge; state stays IDLE.
  - Count = DEPTH: ERR_CODE = 2 (OVERFLOW).
- Operator token:
  - Count < 2: ERR_CODE = 1 (UNDERFLOW).
  - Unknown OP_CODE: ERR_CODE = 4 (BAD_OP).
  - Otherwise latch the operands: A = entry count-2, B = top entry. The result is A op B.
  - Non-division ops go to EXEC. EXEC (BUSY = 1) writes the result to entry count-2, sets count-1, then returns to IDLE. Operator latency is 1 busy cycle.
- Arithmetic:
  - Unsigned, truncated modulo 2^DATA_W.
  - "-" wraps (3 5 - gives 2^DATA_W - 2).
  - "*" keeps the low DATA_W bits.
- END token:
  - Count = 1: next cycle RESULT = entry 0 and RESULT_VLD pulses; count goes to 0.
  - Count != 1: ERR_CODE = 6 (NOT_SINGLE).
- ERROR state:
  - ERR = 1 and BUSY = 1; stack contents are frozen.
  - CLR_STB in any state: count 0, ERR 0, ERR_CODE 0, state IDLE on the next edge. Any pending division is abandoned.
- CLR_STB together with another strobe: CLR wins; the other token is dropped.
- STK_CNT always reflects the registered count.

Optional Feature:
- Macro: RPN_DIV_EN.
- Defined:
  - "/" and "%" are legal.
  - B = 0: ERR_CODE = 3 (DIV_ZERO); no stack change.
  - Otherwise the FSM enters DIV. An iterative restoring divider takes exactly DATA_W cycles, writes the quotient ("/") or remainder ("%") to entry count-2, sets count-1, then returns to IDLE. BUSY = 1 throughout.
- Undefined: "/" and "%" give BAD_OP; no divider logic or DIV state is instantiated.

Decomposition:
- Package rpn_pkg holds:
  - opcode ASCII constants;
  - ERR_CODE constants: UNDERFLOW = 1, OVERFLOW = 2, DIV_ZERO = 3, BAD_OP = 4, PROTOCOL = 5, NOT_SINGLE = 6;
  - the FSM state enum.
- One sub-module, rpn_div: start/done handshake, DATA_W-cycle restoring divider, quotient and remainder outputs. Instantiated only under RPN_DIV_EN.
- The stack is a register array inside rpn_eval.

Test Plan:
- 3, 4, "+", 5, "*", END -> RESULT = 35, RESULT_VLD for 1 cycle, STK_CNT = 0, ERR = 0.
- 3, 5, "-", END -> RESULT = 0xFFFFFFFE (DATA_W = 32).
- 7, "+" -> ERR = 1, ERR_CODE = 1, STK_CNT = 1, BUSY = 1; then CLR_STB -> ERR = 0, STK_CNT = 0, BUSY = 0.
- DEPTH = 16: push 17 numbers -> 17th gives ERR_CODE = 2, STK_CNT = 16.
- NUM_STB and OP_STB in the same cycle -> ERR_CODE = 5, stack unchanged.
- RPN_DIV_EN:
  - 100, 7, "/" -> BUSY for 32 cycles, top = 14.
  - 100, 7, "%" -> top = 2.
  - 5, 0, "/" -> ERR_CODE = 3.
  - RST_N low mid-DIV -> all outputs 0 on the next edge.
